// File: rtl/operand_select_stage.sv
// Operand select stage: picks a vector or scalar source, places and masks it,
// and buffers the result in a 2-entry in-order FIFO.
module operand_select_stage #(
    parameter  int S     = 32,
    parameter  int LANES = 6,
    parameter  int NSRC  = 4,
    localparam int V     = S * LANES,
    localparam int SELW  = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [V-1:0]          vec_in,
    input  logic [(NSRC-1)*S-1:0] scal_in,
    input  logic [SELW-1:0]       sel,
    input  logic                  bcast,
    input  logic [LANES-1:0]      lane_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [V-1:0]          out_data,
    output logic [SELW-1:0]       out_src,
    output logic [1:0]            occ,
    output logic                  sel_err
);

    logic [(1<<SELW)-1:0] legal;
    logic [S-1:0]         scalar;
    logic [S-1:0]         lane;
    logic [V-1:0]         opnd;

    logic [V-1:0]    data_q [2];
    logic [SELW-1:0] src_q  [2];
    logic            wr_q, wr_d;
    logic            rd_q, rd_d;
    logic [1:0]      occ_q, occ_d;
    logic            err_q, err_d;
    logic            push, pop;

    // Codes at or above NSRC exist only when NSRC is not a power of two
    always_comb begin
        for (int k = 0; k < (1 << SELW); k++) begin
            legal[k] = (k < NSRC);
        end
    end

    always_comb begin
        scalar = '0;
        for (int k = 1; k < NSRC; k++) begin
            if (sel == SELW'(k)) begin
                scalar = scal_in[(k-1)*S +: S];
            end
        end
    end

    always_comb begin
        opnd = '0;
        lane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (sel == '0) begin
                lane = vec_in[i*S +: S];
            end else if (legal[sel] && (bcast || i == 0)) begin
                lane = scalar;
            end else begin
                lane = '0;
            end
            if (!lane_mask[i]) begin
                lane = '0;
            end
            opnd[i*S +: S] = lane;
        end
    end

    assign in_ready  = (occ_q != 2'd2) && !rst;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = data_q[rd_q];
    assign out_src   = src_q[rd_q];
    assign occ       = occ_q;
    assign sel_err   = err_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        occ_d = occ_q;
        wr_d  = wr_q ^ push;
        rd_d  = rd_q ^ pop;
        err_d = err_q | (push && !legal[sel]);
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q     <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            src_q[0]  <= '0;
            src_q[1]  <= '0;
        end else begin
            occ_q <= occ_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            err_q <= err_d;
            if (push) begin
                data_q[wr_q] <= opnd;
                src_q[wr_q]  <= sel;
            end
        end
    end

endmodule

// File: tb/tb_operand_select_stage.sv
// Bench for operand_select_stage: directed cases plus a randomized run
// against a lane-level reference model with a queue-based FIFO.
module tb_operand_select_stage;

    localparam int S = 32;
    localparam int L = 6;
    localparam int V = S * L;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [V-1:0]  vec_in, out_data;
    logic [95:0]   scal_in;
    logic [1:0]    sel, out_src, occ;
    logic          bcast, sel_err;
    logic [L-1:0]  lane_mask;

    logic          iv3, ir3, ov3, or3, bc3, err3;
    logic [V-1:0]  vec3, od3;
    logic [63:0]   scal3;
    logic [1:0]    sel3, os3, occ3;
    logic [L-1:0]  mask3;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [V-1:0] data;
        logic [1:0]   src;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    operand_select_stage u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .vec_in(vec_in), .scal_in(scal_in), .sel(sel),
        .bcast(bcast), .lane_mask(lane_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src),
        .occ(occ), .sel_err(sel_err)
    );

    operand_select_stage #(.NSRC(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(iv3), .in_ready(ir3),
        .vec_in(vec3), .scal_in(scal3), .sel(sel3),
        .bcast(bc3), .lane_mask(mask3),
        .out_valid(ov3), .out_ready(or3),
        .out_data(od3), .out_src(os3),
        .occ(occ3), .sel_err(err3)
    );

    function automatic logic [V-1:0] model(
        input logic [V-1:0] v, input logic [95:0] sc, input int s,
        input bit bc, input logic [L-1:0] m, input int nsrc);
        logic [S-1:0] ln [L];
        logic [V-1:0] r;
        for (int i = 0; i < L; i++) begin
            if (s == 0) ln[i] = v[i*S +: S];
            else if (s >= nsrc) ln[i] = '0;
            else if (bc || i == 0) ln[i] = sc[(s-1)*S +: S];
            else ln[i] = '0;
            if (!m[i]) ln[i] = '0;
        end
        for (int i = 0; i < L; i++) r[i*S +: S] = ln[i];
        return r;
    endfunction

    function automatic logic [V-1:0] rvec();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_total++;
        if (occ !== 2'd0 || out_valid !== 1'b0)
            $display("FAIL reset_occ occ=%0d ov=%b want 0/0", occ, out_valid);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b0 || ir3 !== 1'b0)
            $display("FAIL reset_ready got %b/%b want 0", in_ready, ir3);
        else n_pass++;
        n_total++;
        if (out_data !== '0 || out_src !== 2'd0 || sel_err !== 1'b0)
            $display("FAIL reset_data src=%0d err=%b want 0", out_src, sel_err);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b1)
            $display("FAIL release_ready got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_vector_pass();
        logic [V-1:0] v;
        v = 192'h0000000600000005_0000000400000003_0000000200000001;
        vec_in = v; sel = 2'd0; bcast = 1'b1; lane_mask = 6'h3F;
        out_ready = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== v || out_src !== 2'd0)
            $display("FAIL vec_pass ov=%b data=%h src=%0d want 1/%h/0",
                     out_valid, out_data, out_src, v);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total++;
        if (occ !== 2'd0)
            $display("FAIL vec_drain occ=%0d want 0", occ);
        else n_pass++;
    endtask

    task automatic test_bcast_mask();
        logic [V-1:0] e;
        e = {32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        scal_in = {32'h0BAD0BAD, 32'hDEADBEEF, 32'h11111111};
        vec_in = rvec(); sel = 2'd2; bcast = 1'b1; lane_mask = 6'b101010;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (out_data !== e || out_src !== 2'd2)
            $display("FAIL bcast_mask data=%h src=%0d want %h/2",
                     out_data, out_src, e);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_lane0();
        logic [V-1:0] e;
        e = {160'h0, 32'h12345678};
        scal_in = {32'hCAFEF00D, 32'h55555555, 32'h12345678};
        vec_in = rvec(); sel = 2'd1; bcast = 1'b0; lane_mask = 6'h3F;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (out_data !== e || out_src !== 2'd1)
            $display("FAIL lane0 data=%h src=%0d want %h/1",
                     out_data, out_src, e);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [V-1:0] va, ea, eb;
        logic [95:0]  sb;
        va = rvec();
        sb = {$urandom, $urandom, $urandom};
        ea = model(va, sb, 0, 1'b0, 6'h3F, 4);
        eb = model(va, sb, 1, 1'b0, 6'h3F, 4);
        out_ready = 1'b0; lane_mask = 6'h3F; bcast = 1'b0;
        vec_in = va; scal_in = sb; sel = 2'd0; in_valid = 1'b1;
        tick();
        sel = 2'd1;
        tick();
        sel = 2'd2;
        n_total++;
        if (occ !== 2'd2 || in_ready !== 1'b0)
            $display("FAIL bp_full occ=%0d rdy=%b want 2/0", occ, in_ready);
        else n_pass++;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (occ !== 2'd2 || out_data !== ea || out_src !== 2'd0)
            $display("FAIL bp_hold occ=%0d src=%0d want 2/0", occ, out_src);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_data !== eb || out_src !== 2'd1)
            $display("FAIL bp_second ov=%b src=%0d want 1/1", out_valid, out_src);
        else n_pass++;
        tick();
        n_total++;
        if (occ !== 2'd0 || out_valid !== 1'b0)
            $display("FAIL bp_third occ=%0d want 0", occ);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic run_model(input int n, input int pv, input int pr,
                             output int pushes, output int pops);
        logic [V-1:0] e;
        bit dp, dq;
        pushes = 0;
        pops = 0;
        for (int c = 0; c < n; c++) begin
            in_valid = ($urandom_range(99) < pv);
            out_ready = ($urandom_range(99) < pr);
            vec_in = rvec();
            scal_in = {$urandom, $urandom, $urandom};
            sel = 2'($urandom_range(3));
            bcast = 1'($urandom_range(1));
            lane_mask = 6'($urandom_range(63));
            n_total++;
            if (occ !== 2'(q.size()) || in_ready !== (q.size() < 2) ||
                out_valid !== (q.size() != 0))
                $display("FAIL rnd_ctl c=%0d occ=%0d rdy=%b ov=%b want occ=%0d",
                         c, occ, in_ready, out_valid, q.size());
            else n_pass++;
            if (q.size() != 0) begin
                n_total++;
                if (out_data !== q[0].data || out_src !== q[0].src)
                    $display("FAIL rnd_data c=%0d data=%h src=%0d want %h/%0d",
                             c, out_data, out_src, q[0].data, q[0].src);
                else n_pass++;
            end
            dp = in_valid && q.size() < 2;
            dq = out_ready && q.size() != 0;
            e = model(vec_in, scal_in, int'(sel), bcast, lane_mask, 4);
            tick();
            if (dq) begin
                void'(q.pop_front());
                pops++;
            end
            if (dp) begin
                q.push_back('{data: e, src: sel});
                pushes++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        q.delete();
    endtask

    task automatic test_random();
        int pu, po;
        run_model(300, 60, 55, pu, po);
        n_total++;
        if (occ !== 2'd0 || sel_err !== 1'b0)
            $display("FAIL rnd_end occ=%0d err=%b want 0/0", occ, sel_err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pu, po;
        run_model(20, 100, 100, pu, po);
        n_total++;
        if (pu != 20 || po != 19)
            $display("FAIL b2b_rate pushes=%0d pops=%0d want 20/19", pu, po);
        else n_pass++;
    endtask

    task automatic test_illegal_sel();
        logic [V-1:0] e;
        vec3 = rvec(); scal3 = {$urandom, 32'hAAAA5555};
        sel3 = 2'd3; bc3 = 1'b1; mask3 = 6'h3F; or3 = 1'b0; iv3 = 1'b1;
        tick();
        iv3 = 1'b0;
        n_total++;
        if (ov3 !== 1'b1 || od3 !== '0 || os3 !== 2'd3 || err3 !== 1'b1)
            $display("FAIL illegal ov=%b src=%0d err=%b want 1/3/1 zero data",
                     ov3, os3, err3);
        else n_pass++;
        e = model(vec3, {32'h0, scal3}, 1, 1'b1, 6'h3F, 3);
        sel3 = 2'd1; or3 = 1'b1; iv3 = 1'b1;
        tick();
        iv3 = 1'b0;
        n_total++;
        if (od3 !== e || err3 !== 1'b1)
            $display("FAIL illegal_next data=%h err=%b want %h/1", od3, err3, e);
        else n_pass++;
        tick();
        or3 = 1'b0;
        n_total++;
        if (err3 !== 1'b1 || occ3 !== 2'd0)
            $display("FAIL illegal_sticky err=%b occ=%0d want 1/0", err3, occ3);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic [V-1:0] e;
        out_ready = 1'b0; lane_mask = 6'h3F; sel = 2'd0; in_valid = 1'b1;
        vec_in = rvec();
        tick();
        vec_in = rvec();
        tick();
        in_valid = 1'b0;
        n_total++;
        if (occ !== 2'd2)
            $display("FAIL mid_fill occ=%0d want 2", occ);
        else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b0)
            $display("FAIL mid_rst ov=%b occ=%0d rdy=%b want 0/0/0",
                     out_valid, occ, in_ready);
        else n_pass++;
        n_total++;
        if (err3 !== 1'b0 || out_data !== '0)
            $display("FAIL mid_rst_clear err3=%b want 0 zero data", err3);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        scal_in = {$urandom, $urandom, $urandom};
        sel = 2'd3; bcast = 1'b1; lane_mask = 6'($urandom_range(63));
        e = model(vec_in, scal_in, 3, 1'b1, lane_mask, 4);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (occ !== 2'd1 || out_valid !== 1'b1 || out_data !== e || out_src !== 2'd3)
            $display("FAIL mid_after occ=%0d src=%0d data=%h want 1/3/%h",
                     occ, out_src, out_data, e);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_total++;
        if (occ !== 2'd0 || out_valid !== 1'b0)
            $display("FAIL mid_alone occ=%0d want 0", occ);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        vec_in = '0; scal_in = '0; sel = '0; bcast = 1'b0; lane_mask = '0;
        iv3 = 1'b0; or3 = 1'b0; vec3 = '0; scal3 = '0;
        sel3 = '0; bc3 = 1'b0; mask3 = '0;
        test_reset();
        test_vector_pass();
        test_bcast_mask();
        test_lane0();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_illegal_sel();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/operand_select_stage.md
OPERAND_SELECT_STAGE -- requirements
Module: operand_select_stage

Interface
REQ-001 Parameter S, default 32, scalar operand and lane width in bits.
REQ-002 Parameter LANES, default 6, vector lane count; vector width V = S*LANES (192 at defaults).
REQ-003 Parameter NSRC, default 4, number of selectable sources (legal range 2..16); SELW = clog2(NSRC).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers one operand-select transaction.
REQ-007 in_ready  output  1  stage accepts a transaction this cycle.
REQ-008 vec_in  input  V  vector source (source index 0).
REQ-009 scal_in  input  (NSRC-1)*S  packed scalars; source k (1..NSRC-1) = bits [k*S-1:(k-1)*S].
REQ-010 sel  input  SELW  source index.
REQ-011 bcast  input  1  scalar placement mode: 1 = replicate to all lanes, 0 = lane 0 only.
REQ-012 lane_mask  input  LANES  bit i = 0 forces lane i to zero.
REQ-013 out_valid  output  1  out_data/out_src hold a valid result.
REQ-014 out_ready  input  1  downstream consumes the result this cycle.
REQ-015 out_data  output  V  selected, placed, masked operand.
REQ-016 out_src  output  SELW  sel value of the transaction at the head.
REQ-017 occ  output  2  buffered entry count (0..2).
REQ-018 sel_err  output  1  sticky illegal-select flag.

Function
REQ-019 The stage SHALL accept a transaction when in_valid && in_ready at a rising edge (push) and retire one when out_valid && out_ready (pop).
REQ-020 sel = 0 SHALL yield vec_in unchanged before masking.
REQ-021 sel = k, 1 <= k < NSRC, SHALL yield scalar k replicated into every lane when bcast = 1, or in lane 0 with lanes 1..LANES-1 zero when bcast = 0.
REQ-022 bcast SHALL be ignored when sel = 0.
REQ-023 After placement, each lane i with lane_mask[i] = 0 SHALL be zero.
REQ-024 sel >= NSRC (possible only when NSRC is not a power of two) SHALL yield all-zero data, SHALL still be accepted, and SHALL set sel_err at that push edge.
REQ-025 sel_err SHALL remain 1 until reset.
REQ-026 Selection, placement and masking SHALL be evaluated on the inputs at the push edge; the result and sel SHALL be stored in a 2-entry in-order FIFO.
REQ-027 Latency: a push into an empty stage SHALL produce out_valid = 1 with that result in the next cycle.
REQ-028 out_valid SHALL equal (occ != 0); out_data and out_src SHALL show the oldest entry.
REQ-029 in_ready SHALL equal (occ < 2) and !rst, and SHALL have no combinational dependence on out_ready or in_valid.
REQ-030 Simultaneous push and pop at occ = 1 SHALL leave occ = 1, with the new entry at the head next cycle.
REQ-031 A push at occ = 0 SHALL give occ = 1; a push at occ = 1 without a pop SHALL give occ = 2; a pop without a push SHALL decrement occ.
REQ-032 At occ = 2, in_ready SHALL be 0, and in_valid SHALL cause no state change.
REQ-033 While out_valid && !out_ready, out_data and out_src SHALL stay stable.
REQ-034 Sustained in_valid = 1 and out_ready = 1 SHALL achieve one transaction per cycle.

Reset
REQ-035 rst = 1 SHALL immediately force occ = 0, out_valid = 0, out_data = 0, out_src = 0, sel_err = 0, and in_ready = 0.
REQ-036 Assertion of rst mid-operation SHALL discard all buffered entries; the first rising edge after release SHALL be able to accept a push.

Verification
REQ-037 Vector pass: sel = 0, vec_in = 192'h0000000600000005_0000000400000003_0000000200000001, lane_mask = 6'h3F -> next cycle out_valid = 1, out_data = vec_in, out_src = 0.
REQ-038 Broadcast and mask: sel = 2, scalar 2 = 32'hDEADBEEF, bcast = 1, lane_mask = 6'b101010 -> lanes 1, 3 and 5 = DEADBEEF; lanes 0, 2 and 4 = 0.
REQ-039 Lane-0 placement: sel = 1, scalar 1 = 32'h12345678, bcast = 0, lane_mask = 6'h3F -> lane 0 = 12345678, lanes 1..5 = 0.
REQ-040 Backpressure: out_ready = 0 with three pushes offered -> occ reaches 2, in_ready drops to 0, and the third transaction is not accepted; then out_ready = 1 -> outputs appear in push order, one per cycle.
REQ-041 Illegal select: NSRC = 3, sel = 3 -> out_data = 0 and sel_err = 1, which persists across later legal transactions until rst.
REQ-042 Reset mid-stream: occ = 2, then assert rst asynchronously between edges -> out_valid and occ read 0 immediately; after release, a new push appears alone at the next cycle.
